ta_region_writer: RTL and testbench

- Tile-accelerator-side writer of the PVR Region Array.
- On `start`, walks the tile grid and writes one Region Array entry per tile into VRAM: a control word, then one Object List pointer per list type.
- Fmt v1 entries are 5 words; fmt v2 entries are 6 words (adds punch-through).
- It produces exactly the layout the render-side region parser consumes. It sits between TA register decode and the VRAM write arbiter.

---
 rtl/pvr_ra_pkg.sv | 35 +++
 rtl/ra_tile_walker.sv | 34 +++
 rtl/ta_region_writer.sv | 194 +++++++++++++++++++
 tb/tb_ta_region_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pvr_ra_pkg.sv
// rtl/pvr_ra_pkg.sv - shared constants, state encoding and stride helper for the region array writer
package pvr_ra_pkg;

    localparam logic [31:0] RA_EMPTY = 32'h8000_0000;

    // Control word field positions
    localparam int CTRL_LAST   = 31;
    localparam int CTRL_ZCLEAR = 30;
    localparam int CTRL_FLUSH  = 28;
    localparam int CTRL_TY_MSB = 13;
    localparam int CTRL_TY_LSB = 8;
    localparam int CTRL_TX_MSB = 7;
    localparam int CTRL_TX_LSB = 2;

    // Object list type indices, in the order they appear in an entry
    localparam int NUM_LISTS = 5;
    localparam logic [2:0] O  = 3'd0;
    localparam logic [2:0] OM = 3'd1;
    localparam logic [2:0] T  = 3'd2;
    localparam logic [2:0] TM = 3'd3;
    localparam logic [2:0] PT = 3'd4;

    typedef enum logic [3:0] {
        IDLE, SETUP, W_CTRL, W_O, W_OM, W_T, W_TM, W_PT, NEXT, DONE
    } ra_state_t;

    // Bytes one tile consumes in a list: 4<<code words of 4 bytes; code 0 means the list is unused
    function automatic logic [23:0] opb_stride(input logic [1:0] code);
        if (code == 2'd0) begin
            return 24'd0;
        end
        return 24'd16 << code;
    endfunction

endpackage

// File: rtl/ra_tile_walker.sv
// rtl/ra_tile_walker.sv - x-outer / y-inner tile counter for the region array walk
module ra_tile_walker (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    input  logic [5:0] x_max,
    input  logic [5:0] y_max,
    output logic [5:0] tx,
    output logic [5:0] ty,
    output logic       last
);

    assign last = (tx == x_max) && (ty == y_max);

    // Step y first; wrap y and bump x at the end of each column
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx <= '0;
            ty <= '0;
        end else if (clear) begin
            tx <= '0;
            ty <= '0;
        end else if (advance) begin
            if (ty == y_max) begin
                ty <= '0;
                tx <= tx + 6'd1;
            end else begin
                ty <= ty + 6'd1;
            end
        end
    end

endmodule

// File: rtl/ta_region_writer.sv
// rtl/ta_region_writer.sv - writes one PVR Region Array entry per tile into VRAM; TA_RA_WR_CSUM_EN adds a write checksum
module ta_region_writer
    import pvr_ra_pkg::*;
#(
    parameter int VRAM_AW = 24
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        FPU_PARAM_CFG,
    input  logic [31:0]        TA_ALLOC_CTRL,
    input  logic [31:0]        REGION_BASE,
    input  logic [23:0]        o_base,
    input  logic [23:0]        om_base,
    input  logic [23:0]        t_base,
    input  logic [23:0]        tm_base,
    input  logic [23:0]        pt_base,
    input  logic [5:0]         tiles_x_m1,
    input  logic [5:0]         tiles_y_m1,
    input  logic               zclear_flag,
    input  logic               flush_flag,
    output logic               vram_wr,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [31:0]        vram_dout,
    input  logic               vram_busy,
    output logic               busy,
    output logic               done,
    output logic [31:0]        ra_wr_csum
);

    ra_state_t   state, state_nxt;
    logic        fmt_v2, zclear_q, flush_q;
    logic [1:0]  code_q [NUM_LISTS];
    logic [23:0] ptr_q  [NUM_LISTS];
    logic [5:0]  x_max_q, y_max_q;
    logic [5:0]  tx, ty;
    logic        tile_last;
    logic        accept;
    logic        is_list;
    logic [2:0]  list_idx;
    logic [31:0] ctrl_word, list_word;

    // Config bits that play no part in the region array layout
    logic cfg_unused;
    assign cfg_unused = ^{REGION_BASE[31:23], FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                          TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14], TA_ALLOC_CTRL[11:10],
                          TA_ALLOC_CTRL[7:6], TA_ALLOC_CTRL[3:2]};

    ra_tile_walker u_walker (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state == SETUP),
        .advance (state == NEXT),
        .x_max   (x_max_q),
        .y_max   (y_max_q),
        .tx      (tx),
        .ty      (ty),
        .last    (tile_last)
    );

    assign accept = vram_wr && !vram_busy;
    assign busy   = (state != IDLE) && (state != DONE);
    assign done   = (state == DONE);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and write request; each W state waits until its word is accepted
    always_comb begin
        state_nxt = state;
        vram_wr   = 1'b0;
        is_list   = 1'b0;
        list_idx  = O;
        case (state)
            IDLE:   if (start) state_nxt = SETUP;
            SETUP:  state_nxt = W_CTRL;
            W_CTRL: begin
                vram_wr = 1'b1;
                if (!vram_busy) state_nxt = W_O;
            end
            W_O: begin
                vram_wr = 1'b1; is_list = 1'b1; list_idx = O;
                if (!vram_busy) state_nxt = W_OM;
            end
            W_OM: begin
                vram_wr = 1'b1; is_list = 1'b1; list_idx = OM;
                if (!vram_busy) state_nxt = W_T;
            end
            W_T: begin
                vram_wr = 1'b1; is_list = 1'b1; list_idx = T;
                if (!vram_busy) state_nxt = W_TM;
            end
            W_TM: begin
                vram_wr = 1'b1; is_list = 1'b1; list_idx = TM;
                if (!vram_busy) state_nxt = fmt_v2 ? W_PT : NEXT;
            end
            W_PT: begin
                vram_wr = 1'b1; is_list = 1'b1; list_idx = PT;
                if (!vram_busy) state_nxt = NEXT;
            end
            NEXT:   state_nxt = tile_last ? DONE : W_CTRL;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Assemble the control word or the selected list word for the current W state
    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_LAST]   = tile_last;
        ctrl_word[CTRL_ZCLEAR] = zclear_q;
        ctrl_word[CTRL_FLUSH]  = flush_q;
        ctrl_word[CTRL_TY_MSB:CTRL_TY_LSB] = ty;
        ctrl_word[CTRL_TX_MSB:CTRL_TX_LSB] = tx;
        if (code_q[list_idx] == 2'd0) begin
            list_word = RA_EMPTY;
        end else begin
            list_word = {8'h00, ptr_q[list_idx][23:2], 2'b00};
        end
        if (!vram_wr) begin
            vram_dout = '0;
        end else if (is_list) begin
            vram_dout = list_word;
        end else begin
            vram_dout = ctrl_word;
        end
    end

    // Config latch, write address and per-list pointers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fmt_v2    <= 1'b0;
            zclear_q  <= 1'b0;
            flush_q   <= 1'b0;
            x_max_q   <= '0;
            y_max_q   <= '0;
            vram_addr <= '0;
            for (int i = 0; i < NUM_LISTS; i++) begin
                code_q[i] <= '0;
                ptr_q[i]  <= '0;
            end
        end else if (state == SETUP) begin
            fmt_v2    <= FPU_PARAM_CFG[21];
            zclear_q  <= zclear_flag;
            flush_q   <= flush_flag;
            x_max_q   <= tiles_x_m1;
            y_max_q   <= tiles_y_m1;
            vram_addr <= VRAM_AW'(REGION_BASE[22:0]);
            for (int i = 0; i < NUM_LISTS; i++) begin
                code_q[i] <= TA_ALLOC_CTRL[4*i +: 2];
            end
            ptr_q[O]  <= o_base;
            ptr_q[OM] <= om_base;
            ptr_q[T]  <= t_base;
            ptr_q[TM] <= tm_base;
            ptr_q[PT] <= pt_base;
        end else begin
            if (accept) begin
                vram_addr <= vram_addr + VRAM_AW'(4);
            end
            if (state == NEXT) begin
                for (int i = 0; i < NUM_LISTS; i++) begin
                    ptr_q[i] <= ptr_q[i] + opb_stride(code_q[i]);
                end
            end
        end
    end

`ifdef TA_RA_WR_CSUM_EN
    logic [31:0] csum_q;

    // XOR of every accepted word since the last SETUP
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (state == SETUP) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ vram_dout;
        end
    end

    assign ra_wr_csum = csum_q;
`else
    assign ra_wr_csum = 32'h0;
`endif

endmodule

// File: tb/tb_ta_region_writer.sv
// tb/tb_ta_region_writer.sv - randomized self-checking bench for ta_region_writer
module tb_ta_region_writer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] FPU_PARAM_CFG, TA_ALLOC_CTRL, REGION_BASE;
    logic [23:0] o_base, om_base, t_base, tm_base, pt_base;
    logic [5:0]  tiles_x_m1, tiles_y_m1;
    logic        zclear_flag, flush_flag;
    logic        vram_wr;
    logic [23:0] vram_addr;
    logic [31:0] vram_dout;
    logic        vram_busy;
    logic        busy, done;
    logic [31:0] ra_wr_csum;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_csum;
    int          exp_cycles;
    logic [23:0] got_addr[$];
    logic [31:0] got_data[$];
    int          last_done_c;

    ta_region_writer #(.VRAM_AW(24)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .FPU_PARAM_CFG(FPU_PARAM_CFG), .TA_ALLOC_CTRL(TA_ALLOC_CTRL), .REGION_BASE(REGION_BASE),
        .o_base(o_base), .om_base(om_base), .t_base(t_base), .tm_base(tm_base), .pt_base(pt_base),
        .tiles_x_m1(tiles_x_m1), .tiles_y_m1(tiles_y_m1),
        .zclear_flag(zclear_flag), .flush_flag(flush_flag),
        .vram_wr(vram_wr), .vram_addr(vram_addr), .vram_dout(vram_dout), .vram_busy(vram_busy),
        .busy(busy), .done(done), .ra_wr_csum(ra_wr_csum)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_d(input int i);
        return (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [23:0] get_a(input int i);
        return (i < got_addr.size()) ? got_addr[i] : 24'hBAD_BAD;
    endfunction

    task automatic clear_cfg();
        FPU_PARAM_CFG = '0; TA_ALLOC_CTRL = '0; REGION_BASE = '0;
        o_base = '0; om_base = '0; t_base = '0; tm_base = '0; pt_base = '0;
        tiles_x_m1 = '0; tiles_y_m1 = '0; zclear_flag = 1'b0; flush_flag = 1'b0;
    endtask

    task automatic random_cfg();
        FPU_PARAM_CFG = $urandom; TA_ALLOC_CTRL = $urandom; REGION_BASE = $urandom;
        o_base = 24'($urandom); om_base = 24'($urandom); t_base = 24'($urandom);
        tm_base = 24'($urandom); pt_base = 24'($urandom);
        tiles_x_m1 = 6'($urandom_range(0, 3)); tiles_y_m1 = 6'($urandom_range(0, 3));
        zclear_flag = 1'($urandom); flush_flag = 1'($urandom);
    endtask

    // Reference: list of (address, word) the array must contain, built tile by tile
    task automatic build_model();
        logic [23:0] p[5];
        logic [23:0] a;
        logic [31:0] w;
        logic [1:0]  c;
        int          nl;
        exp_addr.delete(); exp_data.delete(); exp_csum = 0;
        p[0] = o_base; p[1] = om_base; p[2] = t_base; p[3] = tm_base; p[4] = pt_base;
        nl = FPU_PARAM_CFG[21] ? 5 : 4;
        a  = {1'b0, REGION_BASE[22:0]};
        for (int x = 0; x <= int'(tiles_x_m1); x++) begin
            for (int y = 0; y <= int'(tiles_y_m1); y++) begin
                w = 32'(y) * 256 + 32'(x) * 4;
                if (x == int'(tiles_x_m1) && y == int'(tiles_y_m1)) w = w + 32'h8000_0000;
                if (zclear_flag) w = w + 32'h4000_0000;
                if (flush_flag)  w = w + 32'h1000_0000;
                exp_addr.push_back(a); exp_data.push_back(w); exp_csum ^= w; a = a + 24'd4;
                for (int t = 0; t < nl; t++) begin
                    c = TA_ALLOC_CTRL[4*t +: 2];
                    w = (c == 0) ? 32'h8000_0000 : {8'h00, p[t] & 24'hFFFFFC};
                    exp_addr.push_back(a); exp_data.push_back(w); exp_csum ^= w; a = a + 24'd4;
                end
                for (int t = 0; t < nl; t++) begin
                    c = TA_ALLOC_CTRL[4*t +: 2];
                    if (c != 0) p[t] = p[t] + (24'd16 << c);
                end
            end
        end
        exp_cycles = 1 + ((int'(tiles_x_m1) + 1) * (int'(tiles_y_m1) + 1)) * (nl + 2);
    endtask

    // Run one array write from a negedge; stall word stall_word for stall_len cycles, plus random stalls
    task automatic run_job(input int stall_word, input int stall_len, input int rand_pct, input bit poke);
        int          nacc = 0, stalls = 0, left = stall_len;
        bit          prev_stall = 0, seen = 0, st;
        logic [23:0] pa = '0;
        logic [31:0] pd = '0;
        build_model();
        got_addr.delete(); got_data.delete();
        last_done_c = -1;
        start = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (c == 0) begin
                start = 1'b0;
                check("busy_after_start", busy, 1'b1);
            end
            if (prev_stall) begin
                check("stall_wr_hold", vram_wr, 1'b1);
                check("stall_addr_hold", vram_addr, pa);
                check("stall_data_hold", vram_dout, pd);
            end
            if (done) begin
                seen = 1; last_done_c = c;
                vram_busy = 1'b0;
                break;
            end
            if (vram_wr) begin
                st = (nacc == stall_word && left > 0) || ($urandom_range(0, 99) < rand_pct);
                if (nacc == stall_word && left > 0) left--;
                if (st) begin
                    stalls++;
                end else begin
                    got_addr.push_back(vram_addr); got_data.push_back(vram_dout); nacc++;
                end
                vram_busy = st;
            end else begin
                vram_busy = 1'($urandom);
            end
            prev_stall = vram_wr && vram_busy;
            pa = vram_addr; pd = vram_dout;
            if (poke && c == 7) begin
                random_cfg();
                start = 1'b1;
            end
            if (poke && c == 8) start = 1'b0;
        end
        check("done_seen", seen, 1'b1);
        check("done_cycle", last_done_c, exp_cycles + stalls);
        check("busy_at_done", busy, 1'b0);
        check("word_count", got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size(); i++) begin
            check("word_addr", get_a(i), exp_addr[i]);
            check("word_data", get_d(i), exp_data[i]);
        end
`ifdef TA_RA_WR_CSUM_EN
        check("csum", ra_wr_csum, exp_csum);
`else
        check("csum_tied", ra_wr_csum, 32'h0);
`endif
        @(negedge clock);
        check("done_pulse", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_wr", vram_wr, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; vram_busy = 1'b0;
        clear_cfg();
        repeat (2) @(negedge clock);
        check("rst_wr", vram_wr, 1'b0);
        check("rst_addr", vram_addr, 24'h0);
        check("rst_dout", vram_dout, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_csum", ra_wr_csum, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // 2x2 fmt v1, opaque list only
        clear_cfg();
        REGION_BASE = 32'h1000; o_base = 24'h100; TA_ALLOC_CTRL = 32'h1;
        tiles_x_m1 = 6'd1; tiles_y_m1 = 6'd1;
        run_job(-1, 0, 0, 0);
        check("t1_done_cycle", last_done_c, 25);
        check("t1_nwords", got_data.size(), 20);
        check("t1_ctrl1", get_d(5), 32'h100);
        check("t1_ctrl2", get_d(10), 32'h4);
        check("t1_ctrl3", get_d(15), 32'h8000_0104);
        check("t1_o3", get_d(16), 32'h160);
        check("t1_om0", get_d(2), 32'h8000_0000);
        check("t1_last_addr", get_a(19), 24'h104C);

        // fmt v2 single tile with punch-through
        clear_cfg();
        FPU_PARAM_CFG = 32'h0020_0000; TA_ALLOC_CTRL = 32'h3_0000; pt_base = 24'h200;
        run_job(-1, 0, 0, 0);
        check("t2_nwords", got_data.size(), 6);
        check("t2_ctrl", get_d(0), 32'h8000_0000);
        check("t2_pt", get_d(5), 32'h200);

        // 3-cycle stall on word 2
        clear_cfg();
        REGION_BASE = 32'h1000; o_base = 24'h100; TA_ALLOC_CTRL = 32'h1;
        tiles_x_m1 = 6'd1; tiles_y_m1 = 6'd1;
        run_job(2, 3, 0, 0);
        check("t3_done_cycle", last_done_c, 28);
        check("t3_last_addr", get_a(19), 24'h104C);

        // translucent pointer wraps at 2^24
        clear_cfg();
        TA_ALLOC_CTRL = 32'h300; t_base = 24'hFFFFC0; tiles_y_m1 = 6'd1;
        run_job(-1, 0, 0, 0);
        check("t4_t0", get_d(3), 32'h00FF_FFC0);
        check("t4_t1", get_d(8), 32'h0000_0040);

        // reset in the middle of an entry, then a clean restart
        clear_cfg();
        REGION_BASE = 32'h2000; TA_ALLOC_CTRL = 32'h1111; tiles_x_m1 = 6'd2;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr", vram_wr, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_addr", vram_addr, 24'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        REGION_BASE = 32'h3000;
        run_job(-1, 0, 20, 0);
        check("t5_first_addr", get_a(0), 24'h3000);

        // second start and config changes mid-run are ignored
        clear_cfg();
        REGION_BASE = 32'h1000; o_base = 24'h100; TA_ALLOC_CTRL = 32'h1;
        tiles_x_m1 = 6'd1; tiles_y_m1 = 6'd1; zclear_flag = 1'b1;
        run_job(-1, 0, 0, 1);

        // randomized configurations with random arbiter stalls
        for (int r = 0; r < 8; r++) begin
            random_cfg();
            run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 25, r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
